multicycle_controller: RTL and testbench

- Control FSM that sequences a shared-memory, single-ALU RISC-V datapath. Each instruction runs over 3–5 cycles.
- Replaces the single-cycle control path; it is the next step toward a multicycle core.
- Drives the datapath's mux selects, write enables and ALU operation, from the opcode/funct fields latched in the instruction register and from the ALU zero flag.
- Supports lw, sw, R-type (add/sub/and/or/slt), I-type ALU (addi/andi/ori/slti), beq and jal.

---
 rtl/multicycle_controller_if.sv | 34 +++
 rtl/multicycle_controller.sv | 168 ++++++++++++++++
 tb/tb_multicycle_controller.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multicycle controller and its datapath.
// The controller uses the slave view; the datapath (or a bench) uses the master view.
interface multicycle_controller_if #(
    parameter int unsigned STATE_W = 4
);
    logic [6:0]         op;
    logic [2:0]         funct3;
    logic               funct7;
    logic               zero;

    logic               pcwrite;
    logic               adrsrc;
    logic               memwrite;
    logic               irwrite;
    logic [1:0]         resultsrc;
    logic [1:0]         alusrca;
    logic [1:0]         alusrcb;
    logic               regwrite;
    logic [1:0]         immsrc;
    logic [2:0]         alu_control;
    logic [STATE_W-1:0] state_dbg;

    modport slave (
        input  op, funct3, funct7, zero,
        output pcwrite, adrsrc, memwrite, irwrite, resultsrc, alusrca, alusrcb,
               regwrite, immsrc, alu_control, state_dbg
    );

    modport master (
        output op, funct3, funct7, zero,
        input  pcwrite, adrsrc, memwrite, irwrite, resultsrc, alusrca, alusrcb,
               regwrite, immsrc, alu_control, state_dbg
    );
endinterface

// File: rtl/multicycle_controller.sv
// Control FSM for a shared-memory, single-ALU RISC-V multicycle datapath.
// Outputs are Moore decodes of state, except pcwrite (zero in BEQ) and immsrc/alu_control (op/funct).
module multicycle_controller #(
    parameter int unsigned STATE_W = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    multicycle_controller_if.slave  bus
);
    localparam int unsigned OP_W  = 7;
    localparam int unsigned ALU_W = 3;

    localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(7'b0000011);
    localparam logic [OP_W-1:0] OP_STORE = OP_W'(7'b0100011);
    localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(7'b0110011);
    localparam logic [OP_W-1:0] OP_ITYPE = OP_W'(7'b0010011);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(7'b1100011);
    localparam logic [OP_W-1:0] OP_JAL   = OP_W'(7'b1101111);

    localparam logic [ALU_W-1:0] ALU_ADD = ALU_W'(3'b000);
    localparam logic [ALU_W-1:0] ALU_SUB = ALU_W'(3'b001);
    localparam logic [ALU_W-1:0] ALU_AND = ALU_W'(3'b010);
    localparam logic [ALU_W-1:0] ALU_OR  = ALU_W'(3'b011);
    localparam logic [ALU_W-1:0] ALU_SLT = ALU_W'(3'b101);

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = STATE_W'(0),
        S_DECODE   = STATE_W'(1),
        S_MEMADR   = STATE_W'(2),
        S_MEMREAD  = STATE_W'(3),
        S_MEMWB    = STATE_W'(4),
        S_MEMWRITE = STATE_W'(5),
        S_EXECR    = STATE_W'(6),
        S_EXECI    = STATE_W'(7),
        S_ALUWB    = STATE_W'(8),
        S_BEQ      = STATE_W'(9),
        S_JAL      = STATE_W'(10)
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               w_pcwrite;
    logic               w_adrsrc;
    logic               w_memwrite;
    logic               w_irwrite;
    logic               w_regwrite;
    logic [1:0]         w_resultsrc;
    logic [1:0]         w_alusrca;
    logic [1:0]         w_alusrcb;
    logic [ALU_W-1:0]   w_alu_control;
    logic [ALU_W-1:0]   w_funct_alu;
    logic [1:0]         w_immsrc;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    // ALU operation requested by funct fields (only consumed in EXECR/EXECI)
    always_comb begin
        w_funct_alu = ALU_ADD;
        case (bus.funct3)
            3'b000:  w_funct_alu = (bus.op[5] & bus.funct7) ? ALU_SUB : ALU_ADD;
            3'b010:  w_funct_alu = ALU_SLT;
            3'b110:  w_funct_alu = ALU_OR;
            3'b111:  w_funct_alu = ALU_AND;
            default: w_funct_alu = ALU_ADD;
        endcase
    end

    always_comb begin
        w_immsrc = 2'b00;
        case (bus.op)
            OP_STORE: w_immsrc = 2'b01;
            OP_BEQ:   w_immsrc = 2'b10;
            OP_JAL:   w_immsrc = 2'b11;
            default:  w_immsrc = 2'b00;
        endcase
    end

    always_comb begin
        w_next        = S_FETCH;
        w_pcwrite     = 1'b0;
        w_adrsrc      = 1'b0;
        w_memwrite    = 1'b0;
        w_irwrite     = 1'b0;
        w_regwrite    = 1'b0;
        w_resultsrc   = 2'b00;
        w_alusrca     = 2'b00;
        w_alusrcb     = 2'b00;
        w_alu_control = ALU_ADD;
        case (r_state)
            S_FETCH: begin
                w_irwrite   = 1'b1;
                w_alusrcb   = 2'b10;
                w_resultsrc = 2'b10;
                w_pcwrite   = 1'b1;
                w_next      = S_DECODE;
            end
            S_DECODE: begin
                w_alusrca = 2'b01;
                w_alusrcb = 2'b01;
                case (bus.op)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_RTYPE:          w_next = S_EXECR;
                    OP_ITYPE:          w_next = S_EXECI;
                    OP_BEQ:            w_next = S_BEQ;
                    OP_JAL:            w_next = S_JAL;
                    default:           w_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                w_alusrca = 2'b10;
                w_alusrcb = 2'b01;
                w_next    = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                w_adrsrc = 1'b1;
                w_next   = S_MEMWB;
            end
            S_MEMWB: begin
                w_resultsrc = 2'b01;
                w_regwrite  = 1'b1;
            end
            S_MEMWRITE: begin
                w_adrsrc   = 1'b1;
                w_memwrite = 1'b1;
            end
            S_EXECR: begin
                w_alusrca     = 2'b10;
                w_alu_control = w_funct_alu;
                w_next        = S_ALUWB;
            end
            S_EXECI: begin
                w_alusrca     = 2'b10;
                w_alusrcb     = 2'b01;
                w_alu_control = w_funct_alu;
                w_next        = S_ALUWB;
            end
            S_ALUWB: w_regwrite = 1'b1;
            S_JAL: begin
                w_alusrca = 2'b01;
                w_alusrcb = 2'b10;
                w_pcwrite = 1'b1;
                w_next    = S_ALUWB;
            end
            S_BEQ: begin
                w_alusrca     = 2'b10;
                w_alu_control = ALU_SUB;
                w_pcwrite     = bus.zero;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Architectural write enables are suppressed while reset is held
    assign bus.pcwrite     = w_pcwrite  & ~reset;
    assign bus.irwrite     = w_irwrite  & ~reset;
    assign bus.regwrite    = w_regwrite & ~reset;
    assign bus.memwrite    = w_memwrite & ~reset;
    assign bus.adrsrc      = w_adrsrc;
    assign bus.resultsrc   = w_resultsrc;
    assign bus.alusrca     = w_alusrca;
    assign bus.alusrcb     = w_alusrcb;
    assign bus.immsrc      = w_immsrc;
    assign bus.alu_control = w_alu_control;
    assign bus.state_dbg   = r_state;
endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed instruction table,
// reset-mid-store sequence and randomized instructions against a path/output model.
module tb_multicycle_controller;
    logic clk;
    logic reset;
    int   errors;
    int   checks;

    multicycle_controller_if #(.STATE_W(4)) bus ();

    multicycle_controller #(.STATE_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcwrite;
        logic       adrsrc;
        logic       memwrite;
        logic       irwrite;
        logic [1:0] resultsrc;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic       regwrite;
        logic [1:0] immsrc;
        logic [2:0] alu;
    } outs_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       zero;
        int         cycles;
        bit         chk_alu;
        logic [2:0] alu;
        int         nmem;
        int         nreg;
        string      name;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic outs_t dut_outs();
        return {bus.pcwrite, bus.adrsrc, bus.memwrite, bus.irwrite, bus.resultsrc,
                bus.alusrca, bus.alusrcb, bus.regwrite, bus.immsrc, bus.alu_control};
    endfunction

    // Instruction path as the list of states visited, from the opcode class
    function automatic int path_len(input logic [6:0] op);
        case (op)
            7'b0000011: return 5;
            7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111: return 4;
            7'b1100011: return 3;
            default:    return 2;
        endcase
    endfunction

    function automatic int path_state(input logic [6:0] op, input int i);
        int p[5];
        p = '{0, 1, 0, 0, 0};
        case (op)
            7'b0000011: p = '{0, 1, 2, 3, 4};
            7'b0100011: p = '{0, 1, 2, 5, 0};
            7'b0110011: p = '{0, 1, 6, 8, 0};
            7'b0010011: p = '{0, 1, 7, 8, 0};
            7'b1100011: p = '{0, 1, 9, 0, 0};
            7'b1101111: p = '{0, 1, 10, 8, 0};
            default:    p = '{0, 1, 0, 0, 0};
        endcase
        return (i < path_len(op)) ? p[i] : 0;
    endfunction

    // Expected outputs for a state, straight from the per-state control table
    function automatic outs_t model_out(input int st, input logic [6:0] op, input logic [2:0] f3,
                                        input logic f7, input logic zero, input logic rst);
        outs_t o;
        logic [2:0] fa;
        o = '0;
        o.immsrc = (op == 7'b0100011) ? 2'd1 : (op == 7'b1100011) ? 2'd2 :
                   (op == 7'b1101111) ? 2'd3 : 2'd0;
        fa = (f3 == 3'd0) ? ((op[5] && f7) ? 3'd1 : 3'd0) : (f3 == 3'd2) ? 3'd5 :
             (f3 == 3'd6) ? 3'd3 : (f3 == 3'd7) ? 3'd2 : 3'd0;
        case (st)
            0:  begin o.irwrite = 1; o.alusrcb = 2; o.resultsrc = 2; o.pcwrite = 1; end
            1:  begin o.alusrca = 1; o.alusrcb = 1; end
            2:  begin o.alusrca = 2; o.alusrcb = 1; end
            3:  o.adrsrc = 1;
            4:  begin o.resultsrc = 1; o.regwrite = 1; end
            5:  begin o.adrsrc = 1; o.memwrite = 1; end
            6:  begin o.alusrca = 2; o.alu = fa; end
            7:  begin o.alusrca = 2; o.alusrcb = 1; o.alu = fa; end
            8:  o.regwrite = 1;
            9:  begin o.alusrca = 2; o.alu = 3'd1; o.pcwrite = zero; end
            10: begin o.alusrca = 1; o.alusrcb = 2; o.pcwrite = 1; end
            default: o = o;
        endcase
        if (rst) begin
            o.pcwrite = 0; o.irwrite = 0; o.regwrite = 0; o.memwrite = 0;
        end
        return o;
    endfunction

    task automatic check_now(input string nm, input int exp_st);
        chk({nm, " state"}, 32'(bus.state_dbg), 32'(exp_st));
        chk({nm, " outs"}, 32'(dut_outs()),
            32'(model_out(exp_st, bus.op, bus.funct3, bus.funct7, bus.zero, reset)));
    endtask

    // Runs one instruction from FETCH; stops when the DUT is back in FETCH (bounded)
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input logic zero_v, input bit rnd_zero, input string nm,
                             output int cyc, output logic [2:0] alu_seen,
                             output int nmem, output int nreg);
        bit done;
        bus.op = op; bus.funct3 = f3; bus.funct7 = f7;
        cyc = 8; alu_seen = '0; nmem = 0; nreg = 0; done = 0;
        for (int i = 0; i < 8 && !done; i++) begin
            bus.zero = rnd_zero ? 1'($urandom_range(0, 1)) : zero_v;
            #1;
            if (i > 0 && bus.state_dbg == 4'd0) begin
                cyc = i;
                done = 1;
            end else begin
                check_now(nm, path_state(op, i));
                if (bus.state_dbg inside {4'd6, 4'd7, 4'd9}) alu_seen = bus.alu_control;
                if (bus.memwrite) nmem++;
                if (bus.regwrite && i > 0) nreg++;
                @(posedge clk); #1;
            end
        end
        chk({nm, " cycles"}, 32'(cyc), 32'(path_len(op)));
    endtask

    vec_t       vecs[$];
    int         cyc, nmem, nreg;
    logic [2:0] alu_seen;
    logic [6:0] ops[7];

    initial begin
        errors = 0; checks = 0;
        reset = 1'b1;
        bus.op = 7'b0000011; bus.funct3 = 3'd0; bus.funct7 = 1'b0; bus.zero = 1'b0;

        vecs.push_back('{7'b0000011, 3'd2, 1'b0, 1'b0, 5, 1'b0, 3'd0, 0, 1, "lw"});
        vecs.push_back('{7'b0110011, 3'd0, 1'b1, 1'b0, 4, 1'b1, 3'd1, 0, 1, "sub"});
        vecs.push_back('{7'b0110011, 3'd0, 1'b0, 1'b0, 4, 1'b1, 3'd0, 0, 1, "add"});
        vecs.push_back('{7'b0110011, 3'd7, 1'b0, 1'b0, 4, 1'b1, 3'd2, 0, 1, "and"});
        vecs.push_back('{7'b0110011, 3'd6, 1'b0, 1'b0, 4, 1'b1, 3'd3, 0, 1, "or"});
        vecs.push_back('{7'b0110011, 3'd2, 1'b0, 1'b0, 4, 1'b1, 3'd5, 0, 1, "slt"});
        vecs.push_back('{7'b0010011, 3'd0, 1'b1, 1'b0, 4, 1'b1, 3'd0, 0, 1, "addi_neg"});
        vecs.push_back('{7'b0010011, 3'd2, 1'b0, 1'b0, 4, 1'b1, 3'd5, 0, 1, "slti"});
        vecs.push_back('{7'b1100011, 3'd0, 1'b0, 1'b1, 3, 1'b1, 3'd1, 0, 0, "beq_taken"});
        vecs.push_back('{7'b1100011, 3'd0, 1'b0, 1'b0, 3, 1'b1, 3'd1, 0, 0, "beq_not"});
        vecs.push_back('{7'b0100011, 3'd2, 1'b0, 1'b0, 4, 1'b0, 3'd0, 1, 0, "sw"});
        vecs.push_back('{7'b1101111, 3'd0, 1'b0, 1'b0, 4, 1'b0, 3'd0, 0, 1, "jal"});
        vecs.push_back('{7'b1111111, 3'd0, 1'b0, 1'b0, 2, 1'b0, 3'd0, 0, 0, "unsupported"});

        repeat (2) @(posedge clk);
        #1;
        chk("reset state", 32'(bus.state_dbg), 32'd0);
        chk("reset pcwrite", 32'(bus.pcwrite), 32'd0);
        chk("reset irwrite", 32'(bus.irwrite), 32'd0);
        reset = 1'b0;

        foreach (vecs[k]) begin
            run_instr(vecs[k].op, vecs[k].f3, vecs[k].f7, vecs[k].zero, 1'b0, vecs[k].name,
                      cyc, alu_seen, nmem, nreg);
            chk({vecs[k].name, " tbl_cycles"}, 32'(cyc), 32'(vecs[k].cycles));
            if (vecs[k].chk_alu) chk({vecs[k].name, " alu"}, 32'(alu_seen), 32'(vecs[k].alu));
            chk({vecs[k].name, " memwrites"}, 32'(nmem), 32'(vecs[k].nmem));
            chk({vecs[k].name, " regwrites"}, 32'(nreg), 32'(vecs[k].nreg));
        end

        // Reset held for three edges while a store sits in MEMWRITE
        bus.op = 7'b0100011; bus.funct3 = 3'd2; bus.zero = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_now("rst_sw walk", path_state(7'b0100011, i));
            @(posedge clk); #1;
        end
        check_now("rst_sw memwrite", 5);
        reset = 1'b1;
        #1;
        check_now("rst_sw held", 5);
        chk("rst_sw memwrite gated", 32'(bus.memwrite), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_now("rst_sw in reset", 0);
            chk("rst_sw pcwrite gated", 32'(bus.pcwrite), 32'd0);
        end
        reset = 1'b0;
        #1;
        check_now("rst_sw release", 0);
        chk("rst_sw fetch irwrite", 32'(bus.irwrite), 32'd1);

        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111, 7'b0000000};
        for (int n = 0; n < 60; n++) begin
            logic [6:0] rop;
            rop = ops[$urandom_range(0, 6)];
            if (rop == 7'b0000000) rop = 7'($urandom_range(0, 127));
            run_instr(rop, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b0, 1'b1,
                      "random", cyc, alu_seen, nmem, nreg);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
